// File: rtl/serial_to_parallel_8bit.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words MSB- or LSB-first into a valid/ready holding register.
// Optional macro PARITY_CHECK_EN adds a trailing even-parity bit per word and a parity_err output.
module serial_to_parallel_8bit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             msb_first,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun
`ifdef PARITY_CHECK_EN
    ,
    output logic             parity_err
`endif
);

`ifdef PARITY_CHECK_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(WIDTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Returns 1 when data plus parity bit hold an odd number of ones.
    function automatic logic parity_odd(input logic [WIDTH-1:0] data, input logic par);
        return (^data) ^ par;
    endfunction

    state_t           state_r, state_nxt_s;
    logic             dir_r, dir_nxt_s, shift_dir_s;
    logic [WIDTH-1:0] sreg_r, sreg_nxt_s, shifted_s;
    logic [CNT_W-1:0] bit_count_r, cnt_nxt_s;
    logic             word_done_s;
    logic [WIDTH-1:0] out_r;
    logic             out_valid_r;
    logic             overrun_r;
    logic             parity_odd_s;

    // Next-state, shift and completion decode for the word assembler.
    always_comb begin
        state_nxt_s  = state_r;
        dir_nxt_s    = dir_r;
        sreg_nxt_s   = sreg_r;
        cnt_nxt_s    = bit_count_r;
        word_done_s  = 1'b0;
        shift_dir_s  = dir_r;
        shifted_s    = sreg_r;
        parity_odd_s = parity_odd(sreg_r, serial_in);

        // The first bit uses the live direction input since dir_r is not yet latched.
        if (state_r == IDLE) begin
            shift_dir_s = msb_first;
        end else begin
            shift_dir_s = dir_r;
        end

        if (shift_dir_s) begin
            shifted_s = {sreg_r[WIDTH-2:0], serial_in};
        end else begin
            shifted_s = {serial_in, sreg_r[WIDTH-1:1]};
        end

        case (state_r)
            IDLE: begin
                if (bit_valid) begin
                    dir_nxt_s   = msb_first;
                    sreg_nxt_s  = shifted_s;
                    cnt_nxt_s   = CNT_ONE;
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    // A trailing parity bit (count == WIDTH) never enters sreg.
                    if (bit_count_r < DATA_CNT) begin
                        sreg_nxt_s = shifted_s;
                    end else begin
                        sreg_nxt_s = sreg_r;
                    end
                    if (bit_count_r == LAST_CNT) begin
                        word_done_s = 1'b1;
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = IDLE;
                    end else begin
                        cnt_nxt_s   = bit_count_r + CNT_ONE;
                        state_nxt_s = SHIFT;
                    end
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Assembler state registers; clear discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            dir_r       <= 1'b1;
            sreg_r      <= {WIDTH{1'b0}};
            bit_count_r <= CNT_ZERO;
        end else if (clear) begin
            state_r     <= IDLE;
            dir_r       <= dir_r;
            sreg_r      <= {WIDTH{1'b0}};
            bit_count_r <= CNT_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            dir_r       <= dir_nxt_s;
            sreg_r      <= sreg_nxt_s;
            bit_count_r <= cnt_nxt_s;
        end
    end

    // Holding register, handshake and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r       <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (clear) begin
            out_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (word_done_s && (!out_valid_r || out_ready)) begin
            out_r       <= sreg_nxt_s;
            out_valid_r <= 1'b1;
        end else if (word_done_s) begin
            overrun_r   <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef PARITY_CHECK_EN
    logic parity_err_r;

    // Parity flag follows the holding register's load/consume/clear rules.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_r <= 1'b0;
        end else if (clear) begin
            parity_err_r <= 1'b0;
        end else if (word_done_s && (!out_valid_r || out_ready)) begin
            parity_err_r <= parity_odd_s;
        end else if (!word_done_s && out_valid_r && out_ready) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= parity_err_r;
        end
    end

    assign parity_err = parity_err_r;
`endif

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign overrun   = overrun_r;
    assign bit_count = bit_count_r;
    assign busy      = (state_r == SHIFT);

endmodule

// File: tb/tb_serial_to_parallel_8bit.sv
// Bench for serial_to_parallel_8bit: bit-queue reference model, per-cycle compare, directed and random stimulus.
module tb_serial_to_parallel_8bit;

`ifdef PARITY_CHECK_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in, bit_valid, msb_first, clear, out_ready;
    logic [7:0] out;
    logic       out_valid, busy, overrun;
    logic [3:0] bit_count;
`ifdef PARITY_CHECK_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad   = 0;

    serial_to_parallel_8bit #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
        .msb_first(msb_first), .clear(clear), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .bit_count(bit_count), .overrun(overrun)
`ifdef PARITY_CHECK_EN
        , .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bits collected in a queue; word built arithmetically on completion.
    bit         q[$];
    bit         m_dir;
    logic [7:0] m_out;
    logic       m_valid, m_ovr, m_perr;
    logic [7:0] w;
    bit         done, par;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete(); m_out = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        end else if (clear) begin
            q.delete(); m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        end else begin
            done = 1'b0;
            if (bit_valid) begin
                if (q.size() == 0) m_dir = msb_first;
                q.push_back(serial_in);
                if (q.size() == NB) begin
                    done = 1'b1;
                    w = 8'h00;
                    for (int i = 0; i < 8; i++) begin
                        if (m_dir) w[7-i] = q[i];
                        else       w[i]   = q[i];
                    end
                    par = 1'b0;
                    foreach (q[i]) par ^= q[i];
                    q.delete();
                end
            end
            if (done && (!m_valid || out_ready)) begin
                m_out = w; m_valid = 1'b1; m_perr = par;
            end else if (done) begin
                m_ovr = 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0; m_perr = 1'b0;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("out", 32'(out), 32'(m_out));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("bit_count", 32'(bit_count), 32'(q.size()));
        chk("busy", 32'(busy), 32'(q.size() != 0));
`ifdef PARITY_CHECK_EN
        chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
    end

    task automatic send_bit(input logic b, input logic m);
        bit_valid = 1'b1; serial_in = b; msb_first = m;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Sends seq[7] first; toggle flips msb_first from the 4th bit; ready_last raises out_ready for the final bit.
    task automatic send_word(input logic [7:0] seq, input logic m, input bit toggle,
                             input bit bad_par, input bit ready_last);
        for (int i = 7; i >= 0; i--) begin
            if (ready_last && i == 0 && NB == 8) out_ready = 1'b1;
            send_bit(seq[i], (toggle && i <= 4) ? ~m : m);
        end
`ifdef PARITY_CHECK_EN
        if (ready_last) out_ready = 1'b1;
        send_bit((^seq) ^ bad_par, ~m);
`endif
        if (ready_last) out_ready = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; serial_in = 1'b0; bit_valid = 1'b0; msb_first = 1'b1;
        clear = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_out", 32'(out), 32'h0);
        chk("reset_cnt", 32'(bit_count), 32'h0);

        // Async reset after 5 bits.
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
        chk("pre_rst_cnt", 32'(bit_count), 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("async_cnt", 32'(bit_count), 32'h0);
        chk("async_valid", 32'(out_valid), 32'h0);
        chk("async_out", 32'(out), 32'h0);
        rst = 1'b0; bit_valid = 1'b0;

        // MSB-first 1,0,1,1,0,0,1,0 -> B2.
        send_word(8'hB2, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("msb_out", 32'(out), 32'hB2);
        chk("msb_model", 32'(m_out), 32'hB2);
        chk("msb_valid", 32'(out_valid), 32'h1);
        idle(2);
        chk("msb_hold", 32'(out), 32'hB2);
        consume();
        chk("msb_consumed", 32'(out_valid), 32'h0);

        // LSB-first same sequence -> 4D, with and without mid-word direction toggle.
        send_word(8'hB2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lsb_out", 32'(out), 32'h4D);
        chk("lsb_model", 32'(m_out), 32'h4D);
        consume();
        send_word(8'hB2, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lsb_toggle_out", 32'(out), 32'h4D);
        consume();

        // Back-to-back words without a consumer -> overrun, old word kept.
        send_word(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("ovr_out", 32'(out), 32'hA5);
        chk("ovr_flag", 32'(overrun), 32'h1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk("clr_ovr", 32'(overrun), 32'h0);
        chk("clr_valid", 32'(out_valid), 32'h0);
        chk("clr_out", 32'(out), 32'hA5);

        // Second word completes on the edge the first is accepted.
        send_word(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("same_edge_out", 32'(out), 32'h3C);
        chk("same_edge_valid", 32'(out_valid), 32'h1);
        chk("same_edge_ovr", 32'(overrun), 32'h0);
        consume();

`ifdef PARITY_CHECK_EN
        send_word(8'hB2, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("par_ok", 32'(parity_err), 32'h0);
        consume();
        send_word(8'hB2, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("par_bad", 32'(parity_err), 32'h1);
        chk("par_bad_out", 32'(out), 32'hB2);
        consume();
`endif

        // Randomized traffic checked by the per-cycle compare.
        for (int c = 0; c < 1500; c++) begin
            bit_valid = ($urandom_range(0, 3) != 0);
            serial_in = $urandom_range(0, 1);
            msb_first = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 80) == 0);
            @(posedge clk); #1;
        end
        bit_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_8bit.md
Name: serial_to_parallel_8bit

Overview:
Serial-to-parallel receiver that reassembles 8-bit words from the serial bit stream our shift-register datapath emits. Each word can be sent MSB-first (left-shift mode) or LSB-first (right-shift mode). Sits at the receiving end of the serial link and presents completed bytes on a valid/ready parallel port, with a one-word holding register and overrun detection.

Parameters:
WIDTH, 8, word length in bits; all tests use 8.
CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > WIDTH (+1 when parity is enabled).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous reset, active-high.
serial_in  input  1  serial data bit.
bit_valid  input  1  serial_in is sampled on a clk edge only when this is 1.
msb_first  input  1  1 = MSB-first, 0 = LSB-first; latched with the first bit of each word.
clear  input  1  synchronous abort/flush.
out  output  WIDTH  completed parallel word (holding register).
out_valid  output  1  out holds an unconsumed word.
out_ready  input  1  consumer accepts out when out_valid && out_ready at a clk edge.
busy  output  1  a partial word is being assembled (bit_count != 0).
bit_count  output  CNT_W  bits received in the current word.
overrun  output  1  sticky; a completed word was dropped because the holding register was full.

Behaviour:
- Reset (rst=1, async): out=0, out_valid=0, overrun=0, bit_count=0, busy=0, shift register=0, latched direction=MSB-first, state=IDLE.
- States:
  - IDLE (bit_count=0).
  - SHIFT (0<bit_count<WIDTH).
  - A completed word leaves the block in IDLE with the holding register loaded. The holding register is tracked separately by out_valid.
- First bit of a word (IDLE, bit_valid=1): latch msb_first into dir_q and enter SHIFT. A change on msb_first mid-word is ignored.
- Per accepted bit:
  - dir_q=1: sreg <= {sreg[WIDTH-2:0], serial_in}.
  - dir_q=0: sreg <= {serial_in, sreg[WIDTH-1:1]}.
  - bit_count increments by 1.
- bit_valid=0 holds all state; gaps between bits are unlimited.
- Word completion (accepted bit makes bit_count reach WIDTH):
  - The completed word is the post-shift sreg value. bit_count returns to 0 on the same edge.
  - If out_valid=0, or out_valid=1 with out_ready=1 on that same edge: out <= word and out_valid=1.
  - Otherwise the new word is dropped, out keeps the old word, and overrun <= 1.
- Latency: out_valid is visible after the same clk edge that samples the last bit (0 cycles after the final bit is registered).
- Handshake:
  - out_valid deasserts after an edge with out_valid && out_ready, unless a new word completes on that same edge.
  - out is stable while out_valid=1 and not accepted.
- overrun stays at 1 until rst or clear.
- clear=1 (sync): bit_count=0, partial word discarded, out_valid=0, overrun=0; out keeps its value.
  - clear has priority over bit_valid and out_ready on the same edge.
- rst asserted mid-word discards everything immediately, without waiting for a clock edge.
- Back-to-back words with bit_valid held at 1 continuously are supported with no idle cycle; the first bit of word N+1 may arrive on the edge after word N completes.
- serial_in is used as sampled. The transmitter drives a known 0/1 whenever bit_valid=1.

Optional Feature:
PARITY_CHECK_EN
- Defined:
  - Each word is followed by one extra parity bit, accepted under bit_valid like a data bit. Completion occurs on that (WIDTH+1)th bit.
  - Even parity over the WIDTH data bits plus the parity bit is checked.
  - An extra output parity_err (1 bit) is loaded along with out and cleared the same way as out_valid.
  - The parity bit is never shifted into sreg.
- Not defined: no parity bit, no parity_err port, completion at WIDTH bits.

Test Plan:
- rst pulse mid-word after 5 bits -> out=0, out_valid=0, bit_count=0 immediately (async); next 8 bits form a clean word.
- msb_first=1, bits 1,0,1,1,0,0,1,0 with out_ready=0 -> out=8'hB2, out_valid=1 after the 8th edge; raise out_ready -> out_valid=0 next edge.
- msb_first=0, same bit sequence -> out=8'h4D. Toggling msb_first after bit 3 still gives 8'h4D.
- Two back-to-back words 8'hA5, 8'h3C with out_ready=0 -> out stays 8'hA5, overrun=1. clear -> overrun=0, out_valid=0.
- Word 2 (8'h3C) completes on the same edge that word 1 (8'hA5) is accepted -> out=8'h3C, out_valid stays 1, overrun=0.
- PARITY_CHECK_EN defined: send 8'hB2 + parity 0 -> parity_err=0; 8'hB2 + parity 1 -> parity_err=1, out=8'hB2.
